sirv_gnrl_pipe_lrv: RTL and testbench

SIRV_GNRL_PIPE_LRV -- requirements
Module: sirv_gnrl_pipe_lrv

---
 rtl/sirv_gnrl_dfflrv.sv | 22 ++
 rtl/sirv_gnrl_pipe_lrv.sv | 106 ++++++++++
 tb/tb_sirv_gnrl_pipe_lrv.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sirv_gnrl_dfflrv.sv
// Load-enabled data register with asynchronous active-low reset to a
// parameterised value; one instance holds the data of one pipe stage.
module sirv_gnrl_dfflrv #(
  parameter int unsigned      DW      = 32,
  parameter logic [DW-1:0]    RST_VAL = '1
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= RST_VAL;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/sirv_gnrl_pipe_lrv.sv
// Bubble-collapsing valid/ready register pipe of DEPTH stages with
// synchronous flush, resettable data stages and a registered occupancy count.
module sirv_gnrl_pipe_lrv #(
  parameter int unsigned      DW      = 32,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [DW-1:0]    RST_VAL = '1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              i_vld,
  output logic                              i_rdy,
  input  logic [DW-1:0]                     i_dat,
  output logic                              o_vld,
  input  logic                              o_rdy,
  output logic [DW-1:0]                     o_dat,
  output logic [$clog2(DEPTH+1)-1:0]        cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] up_vld;
  logic [DEPTH:0]   ld;
  logic [DEPTH-1:0] dat_lden;
  logic [DW-1:0]    dat [DEPTH];

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sum = sum + CW'(v[i]);
    end
    return sum;
  endfunction

  // Load chain is built through a scalar accumulator so the ld vector is never
  // read while it is being assigned (avoids a self-referencing comb vector).
  always_comb begin
    logic acc;
    ld         = '0;
    acc        = o_rdy;
    ld[DEPTH]  = o_rdy;
    for (int unsigned k = DEPTH; k > 0; k--) begin
      acc       = !vld[k-1] | acc;
      ld[k-1]   = acc;
    end
  end

  always_comb begin
    up_vld    = '0;
    up_vld[0] = i_vld;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      up_vld[k] = vld[k-1];
    end
  end

  always_comb begin
    vld_nxt  = vld;
    dat_lden = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (flush) begin
        vld_nxt[k] = 1'b0;
      end else if (ld[k]) begin
        vld_nxt[k] = up_vld[k];
      end
      dat_lden[k] = ld[k] & up_vld[k] & !flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      cnt <= '0;
    end else begin
      vld <= vld_nxt;
      cnt <= popcount(vld_nxt);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [DW-1:0] dnxt;
    if (k == 0) begin : g_first
      assign dnxt = i_dat;
    end else begin : g_rest
      assign dnxt = dat[k-1];
    end

    sirv_gnrl_dfflrv #(
      .DW      (DW),
      .RST_VAL (RST_VAL)
    ) u_dat (
      .lden  (dat_lden[k]),
      .dnxt  (dnxt),
      .qout  (dat[k]),
      .clk   (clk),
      .rst_n (rst_n)
    );
  end

  assign i_rdy = ld[0] & !flush;
  assign o_vld = vld[DEPTH-1] & !flush;
  assign o_dat = dat[DEPTH-1];

endmodule

// File: tb/tb_sirv_gnrl_pipe_lrv.sv
// Directed self-checking bench for sirv_gnrl_pipe_lrv (DW=8, DEPTH=3, RST_VAL=A5).
module tb_sirv_gnrl_pipe_lrv;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CW    = 2;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  sirv_gnrl_pipe_lrv #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .RST_VAL (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .cnt   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    i_vld = 1'b0;
    o_rdy = 1'b0;
    i_dat = '0;

    // Reset
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_o_vld", 32'(o_vld), 32'd0);
    chk("rst_o_dat", 32'(o_dat), 32'hA5);
    chk("rst_cnt",   32'(cnt),   32'd0);
    chk("rst_i_rdy", 32'(i_rdy), 32'd1);

    // Latency: single item into an empty pipe
    i_vld = 1'b1; i_dat = 8'h11; o_rdy = 1'b1;
    #1 chk("lat_i_rdy", 32'(i_rdy), 32'd1);
    tick();
    i_vld = 1'b0; i_dat = 'x;
    #1;
    chk("lat_e1_o_vld", 32'(o_vld), 32'd0);
    chk("lat_e1_cnt",   32'(cnt),   32'd1);
    tick();
    chk("lat_e2_o_vld", 32'(o_vld), 32'd0);
    tick();
    chk("lat_e3_o_vld", 32'(o_vld), 32'd1);
    chk("lat_e3_o_dat", 32'(o_dat), 32'h11);
    tick();
    chk("lat_e4_o_vld", 32'(o_vld), 32'd0);
    chk("lat_e4_cnt",   32'(cnt),   32'd0);

    // Backpressure / full
    o_rdy = 1'b0;
    i_vld = 1'b1; i_dat = 8'h01;
    #1 chk("bp_rdy_01", 32'(i_rdy), 32'd1);
    tick();
    i_dat = 8'h02;
    #1 chk("bp_rdy_02", 32'(i_rdy), 32'd1);
    tick();
    i_dat = 8'h03;
    #1 chk("bp_rdy_03", 32'(i_rdy), 32'd1);
    tick();
    i_dat = 8'h04;
    #1;
    chk("bp_full_cnt",   32'(cnt),   32'd3);
    chk("bp_full_rdy",   32'(i_rdy), 32'd0);
    chk("bp_full_o_vld", 32'(o_vld), 32'd1);
    chk("bp_full_o_dat", 32'(o_dat), 32'h01);
    tick();
    chk("bp_hold_rdy",   32'(i_rdy), 32'd0);
    chk("bp_hold_o_dat", 32'(o_dat), 32'h01);
    chk("bp_hold_cnt",   32'(cnt),   32'd3);
    o_rdy = 1'b1;
    #1 chk("bp_pass_rdy", 32'(i_rdy), 32'd1);
    tick();
    i_vld = 1'b0; i_dat = 'x;
    #1;
    chk("bp_out02", 32'(o_dat), 32'h02);
    chk("bp_cnt3",  32'(cnt),   32'd3);
    tick();
    chk("bp_out03", 32'(o_dat), 32'h03);
    chk("bp_cnt2",  32'(cnt),   32'd2);
    tick();
    chk("bp_out04",   32'(o_dat), 32'h04);
    chk("bp_out04_v", 32'(o_vld), 32'd1);
    chk("bp_cnt1",    32'(cnt),   32'd1);
    tick();
    chk("bp_empty_v", 32'(o_vld), 32'd0);
    chk("bp_empty_c", 32'(cnt),   32'd0);

    // Streaming: 16 items, outputs expected at cycles 3..18
    o_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      i_vld = (c < 16);
      i_dat = (c < 16) ? 8'(8'h20 + c) : 'x;
      #1;
      if (c < 16) chk("st_i_rdy", 32'(i_rdy), 32'd1);
      chk("st_o_vld", 32'(o_vld), (c >= 3 && c < 19) ? 32'd1 : 32'd0);
      if (c >= 3 && c < 19) chk("st_o_dat", 32'(o_dat), 32'(8'h20 + c - 3));
      tick();
    end
    i_vld = 1'b0;

    // Flush with two items stored
    o_rdy = 1'b0;
    i_vld = 1'b1; i_dat = 8'hB1;
    tick();
    i_dat = 8'hB2;
    tick();
    i_vld = 1'b0; i_dat = 'x;
    #1 chk("fl_pre_cnt", 32'(cnt), 32'd2);
    flush = 1'b1; i_vld = 1'b1; i_dat = 8'hB3; o_rdy = 1'b1;
    #1;
    chk("fl_i_rdy", 32'(i_rdy), 32'd0);
    chk("fl_o_vld", 32'(o_vld), 32'd0);
    tick();
    flush = 1'b0; i_vld = 1'b0; i_dat = 'x;
    #1;
    chk("fl_cnt",   32'(cnt),   32'd0);
    chk("fl_o_vld2", 32'(o_vld), 32'd0);
    chk("fl_o_dat", 32'(o_dat), 32'h2F);
    chk("fl_i_rdy2", 32'(i_rdy), 32'd1);
    tick(); tick(); tick();
    chk("fl_no_stale", 32'(o_vld), 32'd0);

    // Reset mid-stream with the pipe full
    o_rdy = 1'b0;
    i_vld = 1'b1; i_dat = 8'hC1; tick();
    i_dat = 8'hC2; tick();
    i_dat = 8'hC3; tick();
    i_vld = 1'b0; i_dat = 'x;
    #1;
    chk("mr_pre_cnt", 32'(cnt),   32'd3);
    chk("mr_pre_dat", 32'(o_dat), 32'hC1);
    rst_n = 1'b0;
    #1;
    chk("mr_async_cnt", 32'(cnt),   32'd0);
    chk("mr_async_dat", 32'(o_dat), 32'hA5);
    chk("mr_async_vld", 32'(o_vld), 32'd0);
    tick();
    rst_n = 1'b1;
    o_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk("mr_no_stale", 32'(o_vld), 32'd0);
      tick();
    end
    i_vld = 1'b1; i_dat = 8'hD1;
    tick();
    i_vld = 1'b0; i_dat = 'x;
    tick();
    chk("mr_lat_e2", 32'(o_vld), 32'd0);
    tick();
    chk("mr_lat_vld", 32'(o_vld), 32'd1);
    chk("mr_lat_dat", 32'(o_dat), 32'hD1);
    tick();
    chk("mr_end_cnt", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
